// File: rtl/uart_rx_core.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_core
//  Purpose  : 16x oversampling UART receiver with a one-entry valid/ack
//             holding register reporting parity, framing and overrun status.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_core #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic [DIV_WIDTH-1:0] baud_div,
    input  logic                 data_size,
    input  logic                 parity_en,
    input  logic [1:0]           parity_mode,
    input  logic                 stop_bit_size,
    output logic [7:0]           data_o,
    output logic                 valid,
    input  logic                 ack,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_START  = 3'd1;
    localparam logic [2:0] c_ST_DATA   = 3'd2;
    localparam logic [2:0] c_ST_PARITY = 3'd3;
    localparam logic [2:0] c_ST_STOP1  = 3'd4;
    localparam logic [2:0] c_ST_STOP2  = 3'd5;

    localparam logic [3:0]           c_OS_S7     = 4'd7;
    localparam logic [3:0]           c_OS_S8     = 4'd8;
    localparam logic [3:0]           c_OS_DECIDE = 4'd9;
    localparam logic [3:0]           c_OS_LAST   = 4'd15;
    localparam logic [DIV_WIDTH-1:0] c_DIV_ZERO  = '0;
    localparam logic [DIV_WIDTH-1:0] c_DIV_ONE   = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

    logic                 r_rx_meta;
    logic                 r_rx_sync;
    logic [2:0]           r_state;
    logic [2:0]           w_next_state;
    logic                 r_armed;
    logic [DIV_WIDTH-1:0] r_div;
    logic                 r_dsize;
    logic                 r_pen;
    logic [1:0]           r_pmode;
    logic                 r_stop2;
    logic [DIV_WIDTH-1:0] r_tick_cnt;
    logic [3:0]           r_os;
    logic                 r_s7;
    logic                 r_s8;
    logic [3:0]           r_bit_cnt;
    logic [7:0]           r_shift;
    logic                 r_par_flag;
    logic                 r_frame_flag;
    logic                 w_tick;
    logic                 w_decide;
    logic                 w_bit_end;
    logic                 w_bit;
    logic                 w_last_data;
    logic [7:0]           w_data;
    logic                 w_par_exp;
    logic                 w_frame_final;
    logic                 w_start;
    logic                 w_complete;

    // rx is asynchronous to clk; both stages idle high so reset looks like a quiet line
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    assign w_tick      = busy && (r_tick_cnt == c_DIV_ZERO);
    assign w_decide    = w_tick && (r_os == c_OS_DECIDE);
    assign w_bit_end   = w_tick && (r_os == c_OS_LAST);
    assign w_bit       = (r_s7 & r_s8) | (r_s7 & r_rx_sync) | (r_s8 & r_rx_sync);
    assign w_last_data = (r_bit_cnt == (r_dsize ? 4'd8 : 4'd7));
    // In 7-bit mode the first data bit sits one position higher in the shifter
    assign w_data      = r_dsize ? r_shift : {1'b0, r_shift[7:1]};
    assign w_par_exp   = r_pmode[1] ? ((^w_data) ^ r_pmode[0]) : r_pmode[0];
    assign w_frame_final = r_frame_flag | ~w_bit;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (r_armed && !r_rx_sync) w_next_state = c_ST_START;
            end
            c_ST_START: begin
                if (w_decide && w_bit)   w_next_state = c_ST_IDLE;
                else if (w_bit_end)      w_next_state = c_ST_DATA;
            end
            c_ST_DATA: begin
                if (w_bit_end && w_last_data)
                    w_next_state = r_pen ? c_ST_PARITY : c_ST_STOP1;
            end
            c_ST_PARITY: begin
                if (w_bit_end) w_next_state = c_ST_STOP1;
            end
            c_ST_STOP1: begin
                if (w_decide && !r_stop2)        w_next_state = c_ST_IDLE;
                else if (w_bit_end && r_stop2)   w_next_state = c_ST_STOP2;
            end
            c_ST_STOP2: begin
                if (w_decide) w_next_state = c_ST_IDLE;
            end
            default: w_next_state = c_ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy       = (r_state != c_ST_IDLE);
        w_start    = (r_state == c_ST_IDLE) && r_armed && !r_rx_sync;
        w_complete = w_decide &&
                     (((r_state == c_ST_STOP1) && !r_stop2) || (r_state == c_ST_STOP2));
    end

    // After a frame ends (possibly mid break) the line must be seen high before re-arming
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_armed <= 1'b1;
        end else if (w_complete) begin
            r_armed <= 1'b0;
        end else if ((r_state == c_ST_IDLE) && r_rx_sync) begin
            r_armed <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div   <= '0;
            r_dsize <= 1'b0;
            r_pen   <= 1'b0;
            r_pmode <= 2'b00;
            r_stop2 <= 1'b0;
        end else if (w_start) begin
            r_div   <= baud_div;
            r_dsize <= data_size;
            r_pen   <= parity_en;
            r_pmode <= parity_mode;
            r_stop2 <= stop_bit_size;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick_cnt <= '0;
            r_os       <= 4'd0;
            r_s7       <= 1'b1;
            r_s8       <= 1'b1;
        end else if (!busy) begin
            r_tick_cnt <= '0;
            r_os       <= 4'd0;
        end else begin
            r_tick_cnt <= (r_tick_cnt == r_div) ? c_DIV_ZERO : r_tick_cnt + c_DIV_ONE;
            if (w_tick) begin
                r_os <= r_os + 4'd1;
                if (r_os == c_OS_S7) r_s7 <= r_rx_sync;
                if (r_os == c_OS_S8) r_s8 <= r_rx_sync;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_cnt    <= 4'd0;
            r_shift      <= 8'h00;
            r_par_flag   <= 1'b0;
            r_frame_flag <= 1'b0;
        end else if (w_start) begin
            r_bit_cnt    <= 4'd0;
            r_shift      <= 8'h00;
            r_par_flag   <= 1'b0;
            r_frame_flag <= 1'b0;
        end else if (w_decide) begin
            case (r_state)
                c_ST_DATA: begin
                    r_shift   <= {w_bit, r_shift[7:1]};
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                end
                c_ST_PARITY: begin
                    if (w_bit != w_par_exp) r_par_flag <= 1'b1;
                end
                c_ST_STOP1, c_ST_STOP2: begin
                    if (!w_bit) r_frame_flag <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Holding register: a completing frame is accepted if the slot is free or freed this cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_o     <= 8'h00;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else if (w_complete) begin
            if (!valid || ack) begin
                data_o     <= w_data;
                parity_err <= r_par_flag;
                frame_err  <= w_frame_final;
                valid      <= 1'b1;
                overrun    <= 1'b0;
            end else begin
                overrun    <= 1'b1;
            end
        end else if (ack && valid) begin
            valid   <= 1'b0;
            overrun <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_core
//  Purpose  : Randomised scoreboard bench for uart_rx_core.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx;
    logic [15:0] cfg_bd;
    logic        cfg_dsize;
    logic        cfg_pen;
    logic [1:0]  cfg_pmode;
    logic        cfg_stop2;
    logic [7:0]  data_o;
    logic        valid;
    logic        ack;
    logic        parity_err;
    logic        frame_err;
    logic        overrun;
    logic        busy;

    logic        auto_ack;
    logic        man_ack;
    logic        ack_en;
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [10:0] exp_q[$];   // {overrun, frame_err, parity_err, data}

    assign ack = auto_ack | man_ack;

    always #5 clk = ~clk;

    uart_rx_core #(.DIV_WIDTH(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .rx            (rx),
        .baud_div      (cfg_bd),
        .data_size     (cfg_dsize),
        .parity_en     (cfg_pen),
        .parity_mode   (cfg_pmode),
        .stop_bit_size (cfg_stop2),
        .data_o        (data_o),
        .valid         (valid),
        .ack           (ack),
        .parity_err    (parity_err),
        .frame_err     (frame_err),
        .overrun       (overrun),
        .busy          (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic ref_parity(input logic [7:0] d, input logic [1:0] m);
        int ones;
        ones = $countones(d);
        case (m)
            2'b11:   return (ones % 2) == 0;
            2'b10:   return (ones % 2) == 1;
            2'b01:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int bitper();
        return 16 * (int'(cfg_bd) + 1);
    endfunction

    // rx fall to valid, in clk edges
    function automatic int ref_latency(input int bits_before_last_stop);
        return (bits_before_last_stop * 16 + 9) * (int'(cfg_bd) + 1) + 4;
    endfunction

    task automatic send_frame(input logic [7:0] b, input int per, input bit flip,
                              input logic [1:0] sz, input bit push, input bit ovr);
        logic [7:0] d;
        logic       par;
        int         nb;
        d   = cfg_dsize ? b : {1'b0, b[6:0]};
        nb  = cfg_dsize ? 8 : 7;
        par = ref_parity(d, cfg_pmode);
        if (push) exp_q.push_back({ovr, sz[0] | (cfg_stop2 & sz[1]), cfg_pen & flip, d});
        @(negedge clk);
        rx = 1'b0;
        repeat (per) @(negedge clk);
        for (int i = 0; i < nb; i++) begin
            rx = d[i];
            repeat (per) @(negedge clk);
        end
        if (cfg_pen) begin
            rx = par ^ flip;
            repeat (per) @(negedge clk);
        end
        rx = ~sz[0];
        repeat (per) @(negedge clk);
        if (cfg_stop2) begin
            rx = ~sz[1];
            repeat (per) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    task automatic gap(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic measure_latency(input int lat_exp);
        int cyc;
        @(negedge clk);
        cyc = 0;
        while (!valid && cyc < lat_exp + 50) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        n_tests++;
        if (!valid || cyc < lat_exp - 2 || cyc > lat_exp + 2) begin
            n_fail++;
            $display("FAIL latency: got %0d clk, expected %0d +/-2", cyc, lat_exp);
        end
    endtask

    task automatic wait_drain(input string name);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < 20000) begin
            @(negedge clk);
            c++;
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s: %0d frames still pending, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor/consumer: compares every frame it takes against the scoreboard
    initial begin
        logic [10:0] e;
        auto_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (valid && ack_en) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_frame: got data %h, expected no frame", data_o);
                end else begin
                    e = exp_q.pop_front();
                    check("frame", 32'({overrun, frame_err, parity_err, data_o}), 32'(e));
                end
                auto_ack = 1'b1;
            end else begin
                auto_ack = 1'b0;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit saw_busy;
        int c;
        int per;
        logic [7:0] b;
        rx = 1'b1; rst = 1'b1; man_ack = 1'b0; ack_en = 1'b1;
        cfg_bd = 16'd3; cfg_dsize = 1'b1; cfg_pen = 1'b0; cfg_pmode = 2'b00; cfg_stop2 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_state", 32'({data_o, valid, parity_err, frame_err, overrun, busy}), 32'd0);

        // 8N1 0xA5 with latency
        fork
            send_frame(8'hA5, bitper(), 1'b0, 2'b00, 1'b1, 1'b0);
            measure_latency(ref_latency(9));
        join
        gap(bitper());

        // 7E2: good frame then flipped parity
        cfg_dsize = 1'b0; cfg_pen = 1'b1; cfg_pmode = 2'b10; cfg_stop2 = 1'b1;
        send_frame(8'h53, bitper(), 1'b0, 2'b00, 1'b1, 1'b0); gap(bitper());
        send_frame(8'h53, bitper(), 1'b1, 2'b00, 1'b1, 1'b0); gap(bitper());

        // odd, mark, space with 8-bit data
        cfg_dsize = 1'b1; cfg_stop2 = 1'b0;
        for (int m = 0; m < 3; m++) begin
            cfg_pmode = (m == 0) ? 2'b11 : ((m == 1) ? 2'b01 : 2'b00);
            b = 8'($urandom);
            send_frame(b, bitper(), 1'b0, 2'b00, 1'b1, 1'b0); gap(bitper());
            send_frame(b, bitper(), 1'b1, 2'b00, 1'b1, 1'b0); gap(bitper());
        end

        // 8N1 stop forced low, then a 20-bit break, then a normal frame
        cfg_pen = 1'b0;
        send_frame(8'h6E, bitper(), 1'b0, 2'b01, 1'b1, 1'b0); gap(bitper());
        exp_q.push_back({1'b0, 1'b1, 1'b0, 8'h00});
        @(negedge clk);
        rx = 1'b0;
        gap(20 * bitper());
        rx = 1'b1;
        gap(2 * bitper());
        send_frame(8'h96, bitper(), 1'b0, 2'b00, 1'b1, 1'b0); gap(bitper());
        wait_drain("break_drain");

        // Glitch of 4 ticks
        saw_busy = 1'b0;
        @(negedge clk);
        rx = 1'b0;
        repeat (4 * (int'(cfg_bd) + 1)) begin
            @(negedge clk);
            saw_busy |= busy;
        end
        rx = 1'b1;
        c = 0;
        while ((busy || !saw_busy) && c < 400) begin
            @(negedge clk);
            saw_busy |= busy;
            c++;
        end
        check("glitch_busy_seen", 32'(saw_busy), 32'd1);
        check("glitch_busy_end", 32'(busy), 32'd0);
        gap(bitper());
        send_frame(8'h3C, bitper(), 1'b0, 2'b00, 1'b1, 1'b0); gap(bitper());
        wait_drain("glitch_drain");

        // Overrun: two frames without ack
        cfg_bd = 16'd1;
        ack_en = 1'b0;
        send_frame(8'h11, bitper(), 1'b0, 2'b00, 1'b1, 1'b1); gap(bitper());
        send_frame(8'h22, bitper(), 1'b0, 2'b00, 1'b0, 1'b0); gap(bitper());
        check("ovr_valid", 32'(valid), 32'd1);
        check("ovr_data", 32'(data_o), 32'h11);
        check("ovr_flag", 32'(overrun), 32'd1);
        ack_en = 1'b1;
        wait_drain("ovr_drain");
        gap(2);
        check("ack_clears", 32'({valid, overrun}), 32'd0);

        // Completion coinciding with ack
        ack_en = 1'b0;
        send_frame(8'h44, bitper(), 1'b0, 2'b00, 1'b0, 1'b0); gap(bitper());
        check("held_44", 32'({valid, data_o}), 32'h144);
        fork
            send_frame(8'h33, bitper(), 1'b0, 2'b00, 1'b1, 1'b0);
            begin
                @(negedge clk);
                repeat (ref_latency(9) - 1) @(posedge clk);
                @(negedge clk);
                man_ack = 1'b1;
                @(negedge clk);
                man_ack = 1'b0;
                check("coincide", 32'({valid, overrun, data_o}), 32'h233);
            end
        join
        gap(bitper());
        ack_en = 1'b1;
        wait_drain("coincide_drain");

        // Reset mid data bit while a frame with errors is held
        cfg_bd = 16'd3;
        per = bitper();
        ack_en = 1'b0;
        send_frame(8'hC3, per, 1'b0, 2'b01, 1'b0, 1'b0); gap(per);
        send_frame(8'h0F, per, 1'b0, 2'b00, 1'b0, 1'b0); gap(per);
        @(negedge clk);
        rx = 1'b0;
        gap(per);
        rx = 1'b1;
        gap(per + per / 2);
        #2 rst = 1'b1;
        #1 check("reset_mid_frame", 32'({data_o, valid, parity_err, frame_err, overrun, busy}), 32'd0);
        @(negedge clk);
        rx = 1'b1;
        gap(3);
        rst = 1'b0;
        ack_en = 1'b1;
        gap(5 * per);
        send_frame(8'h5A, per, 1'b0, 2'b00, 1'b1, 1'b0); gap(per);

        // +/-3% sender baud mismatch
        send_frame(8'h5A, 66, 1'b0, 2'b00, 1'b1, 1'b0); gap(per);
        send_frame(8'h5A, 62, 1'b0, 2'b00, 1'b1, 1'b0); gap(per);
        wait_drain("mismatch_drain");

        // Randomised formats and errors
        for (int k = 0; k < 24; k++) begin
            logic [1:0] sz;
            cfg_bd    = 16'($urandom_range(0, 3));
            cfg_dsize = 1'($urandom);
            cfg_pen   = 1'($urandom);
            cfg_pmode = 2'($urandom);
            cfg_stop2 = 1'($urandom);
            sz = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            if (!cfg_stop2) sz[1] = 1'b0;
            send_frame(8'($urandom), bitper(), ($urandom_range(0, 3) == 0), sz, 1'b1, 1'b0);
            gap(bitper() + $urandom_range(0, bitper()));
        end
        wait_drain("final_drain");
        gap(10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
